// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin arbiter and access sequencer for a single-port SRAM
// macro shared by the wishbone RAM slot (port 0) and a streaming master (port 1).
module ram_arbiter #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 32,
    localparam int unsigned MW = DW / 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          p0_cyc,
    input  logic          p0_we,
    input  logic [MW-1:0] p0_wmsk,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic [DW-1:0] p0_rdata,
    output logic          p0_ack,
    input  logic          p1_cyc,
    input  logic          p1_we,
    input  logic [MW-1:0] p1_wmsk,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic [DW-1:0] p1_rdata,
    output logic          p1_ack,
    output logic          ram_csb,
    output logic          ram_web,
    output logic [MW-1:0] ram_wmask,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_ACK   = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic          gnt_q, gnt_d;
    logic          last_q, last_d;
    logic          csb_q, csb_d;
    logic          web_q, web_d;
    logic [MW-1:0] wmask_q, wmask_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] din_q, din_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          ack0_q, ack0_d;
    logic          ack1_q, ack1_d;

    logic          any_req_c;
    logic          win_c;
    logic          sel_we_c;
    logic [MW-1:0] sel_wmsk_c;
    logic [AW-1:0] sel_addr_c;
    logic [DW-1:0] sel_wdata_c;

    // Pick the winner among current requesters; contention goes to the port that lost last time
    always_comb begin
        win_c = 1'b0;
        case ({p1_cyc, p0_cyc})
            2'b01:   win_c = 1'b0;
            2'b10:   win_c = 1'b1;
            2'b11:   win_c = ~last_q;
            default: win_c = 1'b0;
        endcase
    end

    assign any_req_c   = p0_cyc | p1_cyc;
    assign sel_we_c    = win_c ? p1_we    : p0_we;
    assign sel_wmsk_c  = win_c ? p1_wmsk  : p0_wmsk;
    assign sel_addr_c  = win_c ? p1_addr  : p0_addr;
    assign sel_wdata_c = win_c ? p1_wdata : p0_wdata;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Next-state: one fixed four-cycle pass per granted access
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (any_req_c) state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  state_d = S_ACK;
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Next values of the grant, SRAM control and response registers
    always_comb begin
        gnt_d   = gnt_q;
        last_d  = last_q;
        csb_d   = 1'b1;
        web_d   = 1'b1;
        wmask_d = wmask_q;
        addr_d  = addr_q;
        din_d   = din_q;
        rdata_d = rdata_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (any_req_c) begin
                    gnt_d   = win_c;
                    last_d  = win_c;
                    csb_d   = 1'b0;
                    web_d   = ~sel_we_c;
                    wmask_d = sel_wmsk_c;
                    addr_d  = sel_addr_c;
                    din_d   = sel_wdata_c;
                end
            end
            S_WAIT: begin
                rdata_d = ram_dout;
                ack0_d  = ~gnt_q;
                ack1_d  = gnt_q;
            end
            default: ;
        endcase
    end

    // Registered SRAM controls and response state; reset deselects the macro immediately
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
            csb_q   <= 1'b1;
            web_q   <= 1'b1;
            wmask_q <= '0;
            addr_q  <= '0;
            din_q   <= '0;
            rdata_q <= '0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
        end else begin
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            csb_q   <= csb_d;
            web_q   <= web_d;
            wmask_q <= wmask_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            rdata_q <= rdata_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
        end
    end

    assign ram_csb   = csb_q;
    assign ram_web   = web_q;
    assign ram_wmask = wmask_q;
    assign ram_addr  = addr_q;
    assign ram_din   = din_q;

    // A requester that abandoned its cycle gets no ack; rdata stays zero for OR-combining
    assign p0_ack   = ack0_q & p0_cyc;
    assign p1_ack   = ack1_q & p1_cyc;
    assign p0_rdata = p0_ack ? rdata_q : '0;
    assign p1_rdata = p1_ack ? rdata_q : '0;

endmodule
